game_tick_gen: RTL



---
 rtl/game_tick_gen_pkg.sv | 20 ++
 rtl/game_tick_gen_frame_edge_det.sv | 36 +++
 rtl/game_tick_gen.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/game_tick_gen_pkg.sv
// Shared types and constants for the game tick generator: FSM encoding,
// default 640x480 raster limits and the reload arithmetic width.
package game_tick_gen_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StPaused = 2'b10
    } tick_state_e;

    localparam int unsigned DefHLast = 639;
    localparam int unsigned DefVLast = 479;

    // One guard bit above the wider operand keeps the saturating subtract exact.
    function automatic int unsigned calc_width(input int unsigned div_w,
                                               input int unsigned score_w);
        return ((div_w > score_w) ? div_w : score_w) + 1;
    endfunction

endpackage

// File: rtl/game_tick_gen_frame_edge_det.sv
// Frame-end detector: flags the last active pixel and emits one registered
// pulse on the first cycle of each match, however long the match is held.
module game_tick_gen_frame_edge_det
    import game_tick_gen_pkg::*;
#(
    parameter int unsigned X_W    = 10,
    parameter int unsigned Y_W    = 10,
    parameter int unsigned H_LAST = DefHLast,
    parameter int unsigned V_LAST = DefVLast
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [X_W-1:0] pix_x_i,
    input  logic [Y_W-1:0] pix_y_i,
    output logic           frame_end_o
);

    logic match;
    logic match_q;
    logic frame_end_q;

    assign match = (pix_x_i == X_W'(H_LAST)) && (pix_y_i == Y_W'(V_LAST));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            match_q     <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            match_q     <= match;
            frame_end_q <= match & ~match_q;
        end
    end

    assign frame_end_o = frame_end_q;

endmodule

// File: rtl/game_tick_gen.sv
// Game update timebase: divides the VGA frame rate by a score-dependent divider,
// with run/pause control. Optional single-step while paused: TICK_SINGLE_STEP_EN.
module game_tick_gen
    import game_tick_gen_pkg::*;
#(
    parameter int unsigned X_W           = 10,
    parameter int unsigned Y_W           = 10,
    parameter int unsigned H_LAST        = DefHLast,
    parameter int unsigned V_LAST        = DefVLast,
    parameter int unsigned DIV_W         = 6,
    parameter int unsigned DIV_INIT      = 15,
    parameter int unsigned DIV_MIN       = 3,
    parameter int unsigned SCORE_W       = 8,
    parameter int unsigned SPEEDUP_SHIFT = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic               vga_clk,
    input  logic               sys_reset_n,
    input  logic [X_W-1:0]     pix_x_i,
    input  logic [Y_W-1:0]     pix_y_i,
    input  logic               enable_i,
    input  logic               pause_i,
    input  logic               step_i,
    input  logic [SCORE_W-1:0] score_i,
    output logic               tick_o,
    output logic               upd_clk_o,
    output logic               frame_end_o,
    output logic [DIV_W-1:0]   cur_div_o,
    output logic [CNT_W-1:0]   tick_count_o,
    output logic [1:0]         state_o
);

    localparam int unsigned CalcW = calc_width(DIV_W, SCORE_W);
    localparam logic [DIV_W-1:0] DivInit = DIV_W'(DIV_INIT);

    tick_state_e      state_q, state_d;
    logic [DIV_W-1:0] fcnt_q, fcnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] tick_count_q, tick_count_d;
    logic             upd_clk_q, upd_clk_d;
    logic             tick;
    logic             frame_end;
    logic             div_due;
    logic             step_fire;

    logic [CalcW-1:0] score_steps;
    logic [CalcW-1:0] init_ext;
    logic [CalcW-1:0] floor_ext;
    logic [CalcW-1:0] target_ext;
    logic [DIV_W-1:0] div_target;

    game_tick_gen_frame_edge_det #(
        .X_W    (X_W),
        .Y_W    (Y_W),
        .H_LAST (H_LAST),
        .V_LAST (V_LAST)
    ) u_frame_edge_det (
        .clk_i       (vga_clk),
        .rst_ni      (sys_reset_n),
        .pix_x_i     (pix_x_i),
        .pix_y_i     (pix_y_i),
        .frame_end_o (frame_end)
    );

    // Saturating reload: DIV_INIT - (score >> SPEEDUP_SHIFT), floored at DIV_MIN.
    always_comb begin
        score_steps = CalcW'(score_i) >> SPEEDUP_SHIFT;
        init_ext    = CalcW'(DIV_INIT);
        floor_ext   = CalcW'(DIV_MIN);
        if (score_steps >= (init_ext - floor_ext)) begin
            target_ext = floor_ext;
        end else begin
            target_ext = init_ext - score_steps;
        end
        div_target = DIV_W'(target_ext);
    end

    assign div_due = (fcnt_q == (cur_div_q - DIV_W'(1)));

`ifdef TICK_SINGLE_STEP_EN
    logic [1:0] step_sync_q;
    logic       step_prev_q;
    logic       step_req_q, step_req_d;
    logic       step_rise;
    logic       paused_hold;

    assign paused_hold = (state_q == StPaused) && enable_i && pause_i;
    assign step_rise   = step_sync_q[1] & ~step_prev_q;
    assign step_fire   = paused_hold && step_req_q && frame_end;

    // Request survives only while staying paused; extra edges while armed are absorbed.
    always_comb begin
        step_req_d = 1'b0;
        if (paused_hold) begin
            step_req_d = step_fire ? 1'b0 : (step_req_q | step_rise);
        end
    end

    always_ff @(posedge vga_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            step_sync_q <= 2'b00;
            step_prev_q <= 1'b0;
            step_req_q  <= 1'b0;
        end else begin
            step_sync_q <= {step_sync_q[0], step_i};
            step_prev_q <= step_sync_q[1];
            step_req_q  <= step_req_d;
        end
    end
`else
    logic unused_step;

    assign unused_step = step_i;
    assign step_fire   = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        cur_div_d    = cur_div_q;
        tick_count_d = tick_count_q;
        upd_clk_d    = upd_clk_q;
        tick         = 1'b0;

        unique case (state_q)
            StIdle: begin
                fcnt_d       = '0;
                tick_count_d = '0;
                upd_clk_d    = 1'b0;
                cur_div_d    = DivInit;
                if (enable_i) begin
                    state_d   = StRun;
                    cur_div_d = div_target;
                end
            end
            StRun: begin
                if (!enable_i) begin
                    state_d      = StIdle;
                    fcnt_d       = '0;
                    tick_count_d = '0;
                    upd_clk_d    = 1'b0;
                    cur_div_d    = DivInit;
                end else if (pause_i) begin
                    state_d = StPaused;
                end else if (frame_end) begin
                    if (div_due) begin
                        tick         = 1'b1;
                        fcnt_d       = '0;
                        tick_count_d = tick_count_q + CNT_W'(1);
                        cur_div_d    = div_target;
                        upd_clk_d    = 1'b1;
                    end else begin
                        fcnt_d    = fcnt_q + DIV_W'(1);
                        upd_clk_d = 1'b0;
                    end
                end
            end
            StPaused: begin
                if (!enable_i) begin
                    state_d      = StIdle;
                    fcnt_d       = '0;
                    tick_count_d = '0;
                    upd_clk_d    = 1'b0;
                    cur_div_d    = DivInit;
                end else if (!pause_i) begin
                    state_d = StRun;
                end else if (step_fire) begin
                    tick         = 1'b1;
                    fcnt_d       = '0;
                    tick_count_d = tick_count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge vga_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q      <= StIdle;
            fcnt_q       <= '0;
            cur_div_q    <= DivInit;
            tick_count_q <= '0;
            upd_clk_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            cur_div_q    <= cur_div_d;
            tick_count_q <= tick_count_d;
            upd_clk_q    <= upd_clk_d;
        end
    end

    assign tick_o       = tick;
    assign upd_clk_o    = upd_clk_q;
    assign frame_end_o  = frame_end;
    assign cur_div_o    = cur_div_q;
    assign tick_count_o = tick_count_q;
    assign state_o      = state_q;

endmodule
